alu_arbiter: RTL and testbench

Shares one combinational `alu` instance between two requesters, e.g. the main execute stage and an address or branch helper unit. Round-robin grant with a valid/ready request handshake per requester. The ALU result is captured into a single registered response slot that is tagged with its owner. The response is held until that owner accepts it.

---
 rtl/alu_arbiter.sv | 118 +++++++++++
 tb/tb_alu_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU, with a single registered response slot.
// Define ALU_ARBITER_RR_EN for round-robin arbitration; when it is undefined, requester 0 has fixed priority.
module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [DATA_WIDTH-1:0]    req0_srca,
  input  logic [DATA_WIDTH-1:0]    req0_srcb,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [DATA_WIDTH-1:0]    req1_srca,
  input  logic [DATA_WIDTH-1:0]    req1_srcb,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  output logic                     rsp0_valid,
  input  logic                     rsp0_ready,
  output logic                     rsp1_valid,
  input  logic                     rsp1_ready,
  output logic [DATA_WIDTH-1:0]    rsp_result,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  input  logic [DATA_WIDTH-1:0]    alu_result
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    drain;
  logic                    slot_free;
  logic                    grant;
  logic                    gsel;
`ifdef ALU_ARBITER_RR_EN
  logic                    last_q, last_d;
`endif

  assign rsp0_valid = (state_q == RESP) && !owner_q;
  assign rsp1_valid = (state_q == RESP) &&  owner_q;
  assign rsp_result = result_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    result_d   = result_q;
    grant      = 1'b0;
    gsel       = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_srca   = '0;
    alu_srcb   = '0;
    alu_op     = '0;
`ifdef ALU_ARBITER_RR_EN
    last_d     = last_q;
`endif

    // A draining slot can be refilled in the same cycle, giving full throughput.
    drain     = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);
    slot_free = !reset && ((state_q == IDLE) || drain);

    if (slot_free) begin
      if (req0_valid && req1_valid) begin
        grant = 1'b1;
`ifdef ALU_ARBITER_RR_EN
        gsel  = ~last_q;
`else
        gsel  = 1'b0;
`endif
      end else if (req0_valid) begin
        grant = 1'b1;
        gsel  = 1'b0;
      end else if (req1_valid) begin
        grant = 1'b1;
        gsel  = 1'b1;
      end
    end

    if (grant) begin
      req0_ready = !gsel;
      req1_ready =  gsel;
      alu_srca   = gsel ? req1_srca : req0_srca;
      alu_srcb   = gsel ? req1_srcb : req0_srcb;
      alu_op     = gsel ? req1_op   : req0_op;
      state_d    = RESP;
      owner_d    = gsel;
      result_d   = alu_result;
`ifdef ALU_ARBITER_RR_EN
      last_d     = gsel;
`endif
    end else if (drain) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      result_q <= '0;
`ifdef ALU_ARBITER_RR_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      result_q <= result_d;
`ifdef ALU_ARBITER_RR_EN
      last_q   <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios then randomized traffic against a transaction-level model.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int OW = 4;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;

`ifdef ALU_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
  logic [OW-1:0] req0_op, req1_op;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DW-1:0] rsp_result, alu_srca, alu_srcb, alu_result;
  logic [OW-1:0] alu_op;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_srca(req0_srca), .req0_srcb(req0_srcb), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_srca(req1_srca), .req1_srcb(req1_srcb), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op),
    .alu_result(alu_result)
  );

  function automatic logic [DW-1:0] alu_fn(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_XOR:  return a ^ b;
      OP_SUB:  return a - b;
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op, alu_srca, alu_srcb);

  typedef struct {
    logic          r0, r1;
    logic [DW-1:0] a, b;
    logic [OW-1:0] op;
    logic          v0, v1;
    logic [DW-1:0] res;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference: one result slot with an owner, plus the identity of the last winner.
  bit          m_full  = 1'b0;
  int          m_owner = 0;
  logic [DW-1:0] m_data = '0;
  int          m_last  = 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst,
                      input bit v0, input logic [3:0] op0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                      input bit v1, input logic [3:0] op1, input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                      input bit rr0, input bit rr1, output int g);
    exp_t e;
    bit   accept;
    bit   free;
    @(posedge clk);
    #1;
    reset = rst;
    req0_valid = v0; req0_op = op0; req0_srca = a0; req0_srcb = b0;
    req1_valid = v1; req1_op = op1; req1_srca = a1; req1_srcb = b1;
    rsp0_ready = rr0; rsp1_ready = rr1;

    accept = m_full && ((m_owner == 0) ? rr0 : rr1);
    free   = !rst && (!m_full || accept);
    g = -1;
    if (free) begin
      if (v0 && v1)  g = RR ? ((m_last == 0) ? 1 : 0) : 0;
      else if (v0)   g = 0;
      else if (v1)   g = 1;
    end

    e.r0  = (g == 0);
    e.r1  = (g == 1);
    e.a   = (g == 0) ? a0  : (g == 1) ? a1  : '0;
    e.b   = (g == 0) ? b0  : (g == 1) ? b1  : '0;
    e.op  = (g == 0) ? op0 : (g == 1) ? op1 : '0;
    e.v0  = m_full && (m_owner == 0);
    e.v1  = m_full && (m_owner == 1);
    e.res = m_data;
    expq.push_back(e);

    if (rst) begin
      m_full = 1'b0; m_data = '0; m_last = 1;
    end else if (g >= 0) begin
      m_full  = 1'b1;
      m_owner = g;
      m_last  = g;
      m_data  = (g == 0) ? alu_fn(op0, a0, b0) : alu_fn(op1, a1, b1);
    end else if (accept) begin
      m_full = 1'b0;
    end
  endtask

  task automatic idle(input int n, input bit rr0, input bit rr1);
    int g;
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0, rr0, rr1, g);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("req0_ready", {31'b0, req0_ready}, {31'b0, e.r0});
        chk("req1_ready", {31'b0, req1_ready}, {31'b0, e.r1});
        chk("alu_srca",   alu_srca, e.a);
        chk("alu_srcb",   alu_srcb, e.b);
        chk("alu_op",     {28'b0, alu_op}, {28'b0, e.op});
        chk("rsp0_valid", {31'b0, rsp0_valid}, {31'b0, e.v0});
        chk("rsp1_valid", {31'b0, rsp1_valid}, {31'b0, e.v1});
        chk("rsp_result", rsp_result, e.res);
      end
    end
  end

  initial begin
    int g;
    bit p0v, p1v;
    logic [3:0] p0op, p1op;
    logic [DW-1:0] p0a, p0b, p1a, p1b;
    logic [3:0] ops [5];
    ops[0] = OP_AND; ops[1] = OP_OR; ops[2] = OP_ADD; ops[3] = OP_XOR; ops[4] = OP_SUB;

    reset = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_srca = '0; req0_srcb = '0;
    req1_valid = 1'b0; req1_op = '0; req1_srca = '0; req1_srcb = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0, g);

    // Single ADD, response held one cycle, then drained.
    step(1'b0, 1'b1, OP_ADD, 32'd5, 32'd7, 1'b0, '0, '0, '0, 1'b0, 1'b0, g);
    idle(1, 1'b0, 1'b0);
    idle(2, 1'b1, 1'b1);

    // Contention: SUB 10-3 against XOR F0^0F, sinks always ready.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, OP_SUB, 32'd10, 32'd3, 1'b1, OP_XOR, 32'hF0, 32'h0F, 1'b1, 1'b1, g);
    idle(2, 1'b1, 1'b1);

    // Backpressure on requester 1 while requester 0 waits.
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, OP_AND, 32'hFF, 32'h0F, 1'b1, 1'b1, g);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, OP_ADD, 32'd1, 32'd2, 1'b0, '0, '0, '0, 1'b1, 1'b0, g);
    step(1'b0, 1'b1, OP_ADD, 32'd1, 32'd2, 1'b0, '0, '0, '0, 1'b1, 1'b1, g);
    idle(2, 1'b1, 1'b1);

    // Back-to-back streaming of four ADDs.
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, OP_ADD, DW'(i + 1), '0, 1'b0, '0, '0, '0, 1'b1, 1'b1, g);
    idle(2, 1'b1, 1'b1);

    // Reset while a response is pending, then contention.
    step(1'b0, 1'b1, OP_ADD, 32'd9, 32'd9, 1'b0, '0, '0, '0, 1'b0, 1'b0, g);
    idle(1, 1'b0, 1'b0);
    step(1'b1, 1'b1, OP_ADD, 32'd4, 32'd4, 1'b1, OP_OR, 32'd8, 32'd1, 1'b1, 1'b1, g);
    for (int i = 0; i < 2; i++)
      step(1'b0, 1'b1, OP_SUB, 32'd10, 32'd3, 1'b1, OP_XOR, 32'hF0, 32'h0F, 1'b1, 1'b1, g);
    idle(2, 1'b1, 1'b1);

    // Random traffic; an ungranted request usually stays up with stable payload.
    p0v = 1'b0; p1v = 1'b0; p0op = '0; p1op = '0; p0a = '0; p0b = '0; p1a = '0; p1b = '0;
    g = -1;
    for (int i = 0; i < 600; i++) begin
      if (!(p0v && g != 0 && ($urandom % 4) != 0)) begin
        p0v  = ($urandom % 3) != 0;
        p0op = ops[$urandom % 5];
        p0a  = ($urandom % 2) ? DW'($urandom) : DW'($urandom % 16);
        p0b  = ($urandom % 2) ? DW'($urandom) : DW'($urandom % 16);
      end
      if (!(p1v && g != 1 && ($urandom % 4) != 0)) begin
        p1v  = ($urandom % 3) != 0;
        p1op = ops[$urandom % 5];
        p1a  = ($urandom % 2) ? DW'($urandom) : DW'($urandom % 16);
        p1b  = ($urandom % 2) ? DW'($urandom) : DW'($urandom % 16);
      end
      step(($urandom % 64) == 0, p0v, p0op, p0a, p0b, p1v, p1op, p1a, p1b,
           ($urandom % 4) != 0, ($urandom % 4) != 0, g);
    end

    @(negedge clk);
    #1;
    chk("queue_drained", DW'(expq.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
